// File: rtl/spi_pkg.sv
// Shared types for the parametrised SPI master: FSM state, SPI mode pair and
// the chip-select index width helper.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD  = 2'd1,
    SHIFT = 2'd2,
    TRAIL = 2'd3
  } spi_state_e;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  function automatic int spi_cs_w(input int num_cs);
    return (num_cs > 1) ? $clog2(num_cs) : 1;
  endfunction

endpackage

// File: rtl/spi_master_param_clk_div.sv
// Half-period tick generator: one-cycle tick every CLK_DIV enabled cycles,
// phase realigned by restart so each transfer starts with a full half-period.
module spi_clk_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clock_in,
  input  logic rs_n,
  input  logic enable_i,
  input  logic restart_i,
  output logic tick_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  assign tick_o = enable_i && !restart_i && (cnt_q == LAST);

  always_ff @(posedge clock_in or negedge rs_n) begin
    if (!rs_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_master_param.sv
// Parametrised SPI master: start/busy/done handshake, runtime CPOL/CPHA,
// configurable width, bit order and chip-select count.
module spi_master_param
  import spi_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int CLK_DIV   = 2,
  parameter int NUM_CS    = 1,
  parameter int MSB_FIRST = 1,
  localparam int CS_W     = spi_cs_w(NUM_CS)
) (
  input  logic              clock_in,
  input  logic              rs_n,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              miso,
  output logic              sclk,
  output logic              mosi,
  output logic [NUM_CS-1:0] cs_n,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              led
);

  localparam int EDGES = 2 * DATA_W;
  localparam int EW    = $clog2(EDGES + 1);
  localparam logic [EW-1:0] LAST_EDGE = EW'(EDGES);

  spi_state_e        state_q;
  spi_mode_t         mode_q;
  logic [DATA_W-1:0] tx_q;
  logic [DATA_W-1:0] rx_q;
  logic [EW-1:0]     edge_q;
  logic              sclk_q;
  logic              mosi_q;
  logic [NUM_CS-1:0] cs_n_q;
  logic              busy_q;
  logic              done_q;
  logic [DATA_W-1:0] rx_data_q;
  logic              led_q;

  logic [EW-1:0]     edge_d;
  logic              tick;
  logic              sample_edge;
  logic              shift_edge;
  logic              tx_head;
  logic [DATA_W-1:0] tx_d;
  logic              in_head;
  logic [DATA_W-1:0] in_shift_d;
  logic [DATA_W-1:0] rx_d;
  logic [NUM_CS-1:0] cs_mask;

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clock_in  (clock_in),
    .rs_n      (rs_n),
    .enable_i  (state_q != IDLE),
    .restart_i (state_q == IDLE),
    .tick_o    (tick)
  );

  // Edge numbers are 1-based: odd edges are leading, even edges trailing.
  assign edge_d      = edge_q + EW'(1);
  assign sample_edge = edge_d[0] ^ mode_q.cpha;
  assign shift_edge  = !sample_edge && (edge_d != LAST_EDGE);

  always_comb begin
    if (MSB_FIRST != 0) begin
      tx_head    = tx_q[DATA_W-1];
      tx_d       = {tx_q[DATA_W-2:0], 1'b0};
      in_head    = tx_data[DATA_W-1];
      in_shift_d = {tx_data[DATA_W-2:0], 1'b0};
      rx_d       = {rx_q[DATA_W-2:0], miso};
    end else begin
      tx_head    = tx_q[0];
      tx_d       = {1'b0, tx_q[DATA_W-1:1]};
      in_head    = tx_data[0];
      in_shift_d = {1'b0, tx_data[DATA_W-1:1]};
      rx_d       = {miso, rx_q[DATA_W-1:1]};
    end
  end

  // Out-of-range selects leave every line deasserted.
  for (genvar gi = 0; gi < NUM_CS; gi++) begin : g_cs
    assign cs_mask[gi] = (cs_sel != CS_W'(gi));
  end

  always_ff @(posedge clock_in or negedge rs_n) begin
    if (!rs_n) begin
      state_q   <= IDLE;
      mode_q    <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      edge_q    <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= '1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rx_data_q <= '0;
      led_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          sclk_q <= mode_q.cpol;
          if (start) begin
            mode_q.cpol <= cpol;
            mode_q.cpha <= cpha;
            sclk_q      <= cpol;
            cs_n_q      <= cs_mask;
            busy_q      <= 1'b1;
            edge_q      <= '0;
            state_q     <= LEAD;
            // CPHA=0 needs the first bit on the wire before the leading edge.
            if (!cpha) begin
              mosi_q <= in_head;
              tx_q   <= in_shift_d;
            end else begin
              tx_q   <= tx_data;
            end
          end
        end
        LEAD: begin
          if (tick) state_q <= SHIFT;
        end
        SHIFT: begin
          if (tick) begin
            sclk_q <= ~sclk_q;
            edge_q <= edge_d;
            if (sample_edge) rx_q <= rx_d;
            if (shift_edge) begin
              mosi_q <= tx_head;
              tx_q   <= tx_d;
            end
            if (edge_d == LAST_EDGE) state_q <= TRAIL;
          end
        end
        TRAIL: begin
          if (tick) begin
            state_q   <= IDLE;
            cs_n_q    <= '1;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            rx_data_q <= rx_q;
            led_q     <= ~led_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sclk    = sclk_q;
  assign mosi    = mosi_q;
  assign cs_n    = cs_n_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_data_q;
  assign led     = led_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Directed bench: two master configurations driven against a behavioural SPI
// slave that follows the latched mode and the configured bit order.
module tb_spi_master_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Instance A: 8-bit, T=2, 4 selects, MSB first
  logic       a_rs_n, a_start, a_cpol, a_cpha, a_miso;
  logic [7:0] a_tx, a_rx;
  logic [1:0] a_sel;
  logic       a_sclk, a_mosi, a_busy, a_done, a_led;
  logic [3:0] a_cs_n;
  logic [3:0] a_cs_exp = 4'hF;

  spi_master_param #(.DATA_W(8), .CLK_DIV(2), .NUM_CS(4), .MSB_FIRST(1)) u_a (
    .clock_in(clk), .rs_n(a_rs_n), .start(a_start), .tx_data(a_tx), .cs_sel(a_sel),
    .cpol(a_cpol), .cpha(a_cpha), .miso(a_miso), .sclk(a_sclk), .mosi(a_mosi),
    .cs_n(a_cs_n), .busy(a_busy), .done(a_done), .rx_data(a_rx), .led(a_led)
  );

  // Instance B: 12-bit, T=1, 3 selects, LSB first
  logic        b_rs_n, b_start, b_cpol, b_cpha, b_miso;
  logic [11:0] b_tx, b_rx;
  logic [1:0]  b_sel;
  logic        b_sclk, b_mosi, b_busy, b_done, b_led;
  logic [2:0]  b_cs_n;
  logic [2:0]  b_cs_exp = 3'b111;

  spi_master_param #(.DATA_W(12), .CLK_DIV(1), .NUM_CS(3), .MSB_FIRST(0)) u_b (
    .clock_in(clk), .rs_n(b_rs_n), .start(b_start), .tx_data(b_tx), .cs_sel(b_sel),
    .cpol(b_cpol), .cpha(b_cpha), .miso(b_miso), .sclk(b_sclk), .mosi(b_mosi),
    .cs_n(b_cs_n), .busy(b_busy), .done(b_done), .rx_data(b_rx), .led(b_led)
  );

  // Behavioural slaves, index 0 = A, 1 = B
  logic        s_busy [2];
  logic        s_sclk [2];
  logic        s_mosi [2];
  logic        s_miso [2]  = '{1'b0, 1'b0};
  logic        s_pbusy [2] = '{1'b0, 1'b0};
  logic        s_psclk [2] = '{1'b0, 1'b0};
  logic        s_pha [2]   = '{1'b0, 1'b0};
  logic [31:0] s_word [2]  = '{32'h0, 32'h0};
  logic [31:0] s_rx [2]    = '{32'h0, 32'h0};
  int          s_edges [2] = '{0, 0};
  int          s_si [2]    = '{0, 0};
  int          s_oi [2]    = '{0, 0};
  int          a_csbad = 0, b_csbad = 0, a_dcnt = 0, b_dcnt = 0;

  assign s_busy[0] = a_busy;
  assign s_busy[1] = b_busy;
  assign s_sclk[0] = a_sclk;
  assign s_sclk[1] = b_sclk;
  assign s_mosi[0] = a_mosi;
  assign s_mosi[1] = b_mosi;
  assign a_miso    = s_miso[0];
  assign b_miso    = s_miso[1];

  function automatic int wid(input int i);
    return (i == 0) ? 8 : 12;
  endfunction

  function automatic int bpos(input int i, input int n);
    return (i == 0) ? (7 - n) : n;
  endfunction

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      if (s_busy[i] && !s_pbusy[i]) begin
        s_pha[i]   = (i == 0) ? a_cpha : b_cpha;
        s_edges[i] = 0;
        s_si[i]    = 0;
        s_oi[i]    = 0;
        s_rx[i]    = '0;
        if (!s_pha[i]) begin
          s_miso[i] = s_word[i][bpos(i, 0)];
          s_oi[i]   = 1;
        end
      end else if (s_busy[i] && s_pbusy[i] && (s_sclk[i] != s_psclk[i])) begin
        s_edges[i]++;
        if (((s_edges[i] % 2) == 1) ^ s_pha[i]) begin
          if (s_si[i] < wid(i)) s_rx[i][bpos(i, s_si[i])] = s_mosi[i];
          s_si[i]++;
        end else if (s_oi[i] < wid(i)) begin
          s_miso[i] = s_word[i][bpos(i, s_oi[i])];
          s_oi[i]++;
        end
      end
      s_pbusy[i] = s_busy[i];
      s_psclk[i] = s_sclk[i];
    end
    if (a_busy && (a_cs_n !== a_cs_exp)) a_csbad++;
    if (b_busy && (b_cs_n !== b_cs_exp)) b_csbad++;
    if (a_done) a_dcnt++;
    if (b_done) b_dcnt++;
  end

  task automatic a_wait_done(output int lat);
    lat = 0;
    while (a_done !== 1'b1 && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic a_run(input logic [7:0] d, input logic [1:0] sel, input logic pol,
                       input logic pha, input logic [7:0] sw, input bit poke,
                       output int lat, output logic sclk0);
    s_word[0] = {24'h0, sw};
    a_tx = d; a_sel = sel; a_cpol = pol; a_cpha = pha;
    a_cs_exp = ~(4'b0001 << sel);
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    sclk0 = a_sclk;
    lat = 0;
    while (a_done !== 1'b1 && lat < 400) begin
      @(posedge clk); #1;
      lat++;
      if (poke) a_start = (lat == 10);
    end
    a_start = 1'b0;
    $display("A tx=%h cpol=%0d cpha=%0d rx=%h slave_rx=%h lat=%0d", d, pol, pha, a_rx, s_rx[0][7:0], lat);
  endtask

  task automatic b_run(input logic [11:0] d, input logic [1:0] sel, input logic pol,
                       input logic pha, input logic [11:0] sw, output int lat);
    s_word[1] = {20'h0, sw};
    b_tx = d; b_sel = sel; b_cpol = pol; b_cpha = pha;
    b_cs_exp = (sel < 2'd3) ? ~(3'b001 << sel) : 3'b111;
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    lat = 0;
    while (b_done !== 1'b1 && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
    $display("B tx=%h sel=%0d cpol=%0d cpha=%0d rx=%h slave_rx=%h lat=%0d", d, sel, pol, pha, b_rx, s_rx[1][11:0], lat);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  logic [1:0] modes [3] = '{2'b01, 2'b10, 2'b11};
  logic [7:0] sws [3]   = '{8'h5A, 8'h96, 8'h0F};

  initial begin
    int   lat;
    int   snap;
    logic s0;
    logic led_exp;

    a_rs_n = 1'b0; b_rs_n = 1'b0;
    a_start = 1'b0; a_tx = '0; a_sel = '0; a_cpol = 1'b0; a_cpha = 1'b0;
    b_start = 1'b0; b_tx = '0; b_sel = '0; b_cpol = 1'b0; b_cpha = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("a_reset", {a_sclk, a_mosi, a_cs_n, a_busy, a_done, a_led, a_rx}, {2'b00, 4'hF, 3'b000, 8'h00});
    chk("b_reset", {b_sclk, b_mosi, b_cs_n, b_busy, b_done, b_led, b_rx}, {2'b00, 3'b111, 3'b000, 12'h000});
    a_rs_n = 1'b1; b_rs_n = 1'b1;
    @(posedge clk); #1;

    // Mode 0 basic
    a_run(8'hA5, 2'd0, 1'b0, 1'b0, 8'h3C, 1'b0, lat, s0);
    led_exp = 1'b1;
    chk("m0_lat", lat, 36);
    chk("m0_rx", a_rx, 8'h3C);
    chk("m0_mosi_bits", s_rx[0], 32'hA5);
    chk("m0_edges", s_edges[0], 16);
    chk("m0_led", a_led, led_exp);
    chk("m0_end_cs", {a_busy, a_cs_n}, 5'b0_1111);
    chk("m0_sclk_idle", {s0, a_sclk}, 2'b00);
    @(posedge clk); #1;
    chk("m0_done_1cyc", a_done, 1'b0);

    // Modes 1..3; the last run pokes start mid-transfer
    for (int m = 0; m < 3; m++) begin
      a_run(8'hC3, 2'd1, modes[m][1], modes[m][0], sws[m], (m == 2), lat, s0);
      led_exp = ~led_exp;
      chk("mode_lat", lat, 36);
      chk("mode_rx", a_rx, sws[m]);
      chk("mode_slave", s_rx[0], 32'hC3);
      chk("mode_sclk_before", s0, modes[m][1]);
      chk("mode_sclk_after", a_sclk, modes[m][1]);
      chk("mode_led", a_led, led_exp);
      @(posedge clk); #1;
      chk("mode_no_queue", {a_busy, a_done}, 2'b00);
    end

    // Back-to-back with start held, cs_sel=2
    s_word[0] = 32'h99;
    a_tx = 8'h66; a_sel = 2'd2; a_cpol = 1'b0; a_cpha = 1'b0;
    a_cs_exp = 4'b1011;
    snap = a_csbad;
    a_start = 1'b1;
    @(posedge clk); #1;
    a_wait_done(lat);
    $display("A b2b word1 rx=%h slave_rx=%h lat=%0d", a_rx, s_rx[0][7:0], lat);
    chk("b2b_lat1", lat, 36);
    chk("b2b_rx1", a_rx, 8'h99);
    chk("b2b_slave1", s_rx[0], 32'h66);
    chk("b2b_gap", {a_busy, a_cs_n}, 5'b0_1111);
    @(posedge clk); #1;
    chk("b2b_restart", {a_busy, a_cs_n}, 5'b1_1011);
    a_start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    a_tx = 8'hFF; a_cpol = 1'b1; a_cpha = 1'b1; a_sel = 2'd0;
    a_wait_done(lat);
    $display("A b2b word2 rx=%h slave_rx=%h lat=%0d", a_rx, s_rx[0][7:0], lat + 5);
    chk("b2b_lat2", lat + 5, 36);
    chk("b2b_slave2", s_rx[0], 32'h66);
    chk("b2b_edges2", s_edges[0], 16);
    chk("b2b_sclk_latched", a_sclk, 1'b0);
    chk("b2b_cs_during", a_csbad - snap, 0);
    @(posedge clk); #1;
    chk("b2b_stop", a_busy, 1'b0);

    // Reset in half-period 5 of a transfer
    s_word[0] = 32'hE7;
    a_tx = 8'h5A; a_sel = 2'd0; a_cpol = 1'b1; a_cpha = 1'b0;
    a_cs_exp = 4'b1110;
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    snap = a_dcnt;
    a_rs_n = 1'b0;
    #1;
    chk("rst_mid", {a_sclk, a_mosi, a_cs_n, a_busy, a_done, a_led, a_rx}, {2'b00, 4'hF, 3'b000, 8'h00});
    repeat (3) begin @(posedge clk); #1; end
    a_rs_n = 1'b1;
    repeat (40) begin @(posedge clk); #1; end
    chk("rst_no_done", a_dcnt - snap, 0);
    chk("rst_idle", a_busy, 1'b0);
    a_run(8'h81, 2'd1, 1'b0, 1'b0, 8'hE7, 1'b0, lat, s0);
    chk("rst_after_lat", lat, 36);
    chk("rst_after_rx", a_rx, 8'hE7);
    chk("rst_after_slave", s_rx[0], 32'h81);
    chk("rst_after_led", a_led, 1'b1);

    // Instance B: LSB first, 12 bits, T=1, out-of-range select
    snap = b_csbad;
    b_run(12'h801, 2'd0, 1'b0, 1'b0, 12'hABC, lat);
    chk("lsb_lat", lat, 26);
    chk("lsb_rx", b_rx, 12'hABC);
    chk("lsb_slave", s_rx[1], 32'h801);
    chk("lsb_first_bit", s_rx[1][0], 1'b1);
    chk("lsb_second_bit", s_rx[1][1], 1'b0);
    chk("lsb_edges", s_edges[1], 24);
    chk("lsb_end_cs", {b_busy, b_cs_n}, 4'b0_111);
    @(posedge clk); #1;
    snap = b_dcnt;
    b_run(12'h5A5, 2'd3, 1'b1, 1'b1, 12'h3C3, lat);
    chk("oor_lat", lat, 26);
    chk("oor_rx", b_rx, 12'h3C3);
    chk("oor_slave", s_rx[1], 32'h5A5);
    chk("oor_sclk", b_sclk, 1'b1);
    chk("oor_led", b_led, 1'b0);
    @(posedge clk); #1;
    chk("oor_done_cnt", b_dcnt - snap, 1);
    chk("b_cs_during", b_csbad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
